// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encoding and control record for the multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Attributes of the in-flight operation, captured at acceptance.
  typedef struct packed {
    logic is_div;  // shift-subtract instead of shift-add
    logic neg_q;   // negate product / quotient at FIX
    logic neg_r;   // negate remainder at FIX
    logic dz;      // divisor was zero: RUN is skipped
  } ctl_t;

endpackage

// File: rtl/mdu_datapath.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
// i_hi/i_lo hold {P_hi,P_lo} for multiply or {R,Q} for divide; i_m is the
// multiplicand or divisor magnitude.
module mdu_datapath #(
  parameter int XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_m,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rsh;
  logic [XLEN:0] w_diff;

  // Since R < divisor always holds, the 33-bit difference's MSB is a clean
  // "trial went negative" indicator.
  always_comb begin
    w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : '0);
    w_rsh  = {i_hi, i_lo[XLEN-1]};
    w_diff = w_rsh - {1'b0, i_m};
    if (i_is_div) begin
      if (!w_diff[XLEN]) begin
        o_hi = w_diff[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b1};
      end else begin
        o_hi = w_rsh[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Magnitudes are iterated for 32 cycles, signs are applied in a FIX cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_by_zero
);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_ph, r_pl, r_m;
  logic [XLEN-1:0]   r_hi, r_lo;
  ctl_t              r_ctl;
  logic              r_done, r_dz;

  logic              w_accept, w_md, w_isdiv, w_sgn, w_zero;
  logic [XLEN-1:0]   w_absA, w_absB;
  logic [XLEN-1:0]   w_step_hi, w_step_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_fix_hi, w_fix_lo;

  // Issue decode and operand magnitudes.
  always_comb begin
    w_accept = (r_state == S_IDLE) && start;
    w_md     = w_accept && !op[2];
    w_isdiv  = (op == OP_DIV) || (op == OP_DIVU);
    w_sgn    = (op == OP_MULT) || (op == OP_DIV);
    w_zero   = w_isdiv && (dataB == '0);
    w_absA   = (w_sgn && dataA[XLEN-1]) ? -dataA : dataA;
    w_absB   = (w_sgn && dataB[XLEN-1]) ? -dataB : dataB;
  end

  mdu_datapath #(.XLEN(XLEN)) u_dp (
    .i_is_div (r_ctl.is_div),
    .i_hi     (r_ph),
    .i_lo     (r_pl),
    .i_m      (r_m),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  // Sign fix-up of the finished magnitudes; div-by-zero returns the raw dividend.
  always_comb begin
    w_prod   = r_ctl.neg_q ? -{r_ph, r_pl} : {r_ph, r_pl};
    w_fix_hi = w_prod[2*XLEN-1:XLEN];
    w_fix_lo = w_prod[XLEN-1:0];
    if (r_ctl.dz) begin
      w_fix_hi = r_pl;
      w_fix_lo = '1;
    end else if (r_ctl.is_div) begin
      w_fix_hi = r_ctl.neg_r ? -r_ph : r_ph;
      w_fix_lo = r_ctl.neg_q ? -r_pl : r_pl;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_md) w_next = w_zero ? S_FIX : S_RUN;
      S_RUN:   if (r_cnt == CNT_W'(ITER - 1)) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration, HI/LO writeback and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_ph   <= '0;
      r_pl   <= '0;
      r_m    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_ctl  <= '0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (w_md) begin
            r_dz         <= 1'b0;
            r_cnt        <= '0;
            r_ph         <= '0;
            r_ctl.is_div <= w_isdiv;
            r_ctl.neg_q  <= w_sgn && (dataA[XLEN-1] ^ dataB[XLEN-1]);
            r_ctl.neg_r  <= w_sgn && dataA[XLEN-1];
            r_ctl.dz     <= w_zero;
            if (w_isdiv) begin
              r_pl <= w_zero ? dataA : w_absA;
              r_m  <= w_absB;
            end else begin
              r_pl <= w_absB;
              r_m  <= w_absA;
            end
          end else if (w_accept && op == OP_MTHI) begin
            r_hi <= dataA;
          end else if (w_accept && op == OP_MTLO) begin
            r_lo <= dataA;
          end
        end
        S_RUN: begin
          r_ph  <= w_step_hi;
          r_pl  <= w_step_lo;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_hi  <= w_fix_hi;
          r_lo  <= w_fix_lo;
          r_cnt <= '0;
          if (r_ctl.dz) r_dz <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, corner sequences and
// random operations compared against an arithmetic reference model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] dataA, dataB;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    logic        edz;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Reference: plain 64-bit arithmetic, truncating division.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    logic [63:0] p;
    longint sa, sb;
    p = '0; edz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  p = 64'(sa * sb);
      OP_MULTU: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 0) begin
          p = {a, 32'hFFFFFFFF}; edz = 1'b1;
        end else if (o == OP_DIV) begin
          p = {32'(sa % sb), 32'(sa / sb)};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    eh = p[63:32]; el = p[31:0];
  endfunction

  // Issue one mult/div, wait (bounded) for done, check results and timing.
  task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input logic edz, input bit scr, input int inj);
    int n, bc;
    op = o; dataA = a; dataB = b; start = 1'b1;
    tick;
    start = 1'b0; n = 1; bc = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      if (n == inj) begin
        start = 1'b1; op = OP_MULT; dataA = 32'd7; dataB = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (scr) begin dataA = $urandom; dataB = $urandom; end
      tick;
      n++;
    end
    start = 1'b0;
    chk({nm, " done_cycle"}, n, edz ? 2 : 34);
    chk({nm, " busy_cycles"}, bc, edz ? 1 : 33);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    chk({nm, " dz"}, {31'b0, div_by_zero}, {31'b0, edz});
    tick;
    chk({nm, " done_pulse"}, {31'b0, done}, 0);
    chk({nm, " idle_after"}, {31'b0, busy}, 0);
  endtask

  initial begin
    logic [31:0] eh, el, sh, sl, a, b;
    logic        edz;
    logic [2:0]  o;

    tbl[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[1] = '{OP_MULT,  32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    tbl[2] = '{OP_DIV,   32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    tbl[3] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tbl[4] = '{OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
    tbl[5] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tbl[6] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tbl[7] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    tbl[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tbl[9] = '{OP_DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};

    rst = 1'b1; start = 1'b0; op = '0; dataA = '0; dataB = '0;
    tick; tick;
    rst = 1'b0;
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset dz", {31'b0, div_by_zero}, 0);

    foreach (tbl[i])
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
            tbl[i].eh, tbl[i].el, tbl[i].edz, 1'b1, 0);

    // MTHI then MTLO on consecutive idle edges.
    start = 1'b1; op = OP_MTHI; dataA = 32'hAAAA5555;
    tick;
    chk("mthi hi", hi, 32'hAAAA5555);
    chk("mthi busy", {31'b0, busy}, 0);
    op = OP_MTLO; dataA = 32'h0F0F0F0F;
    tick;
    start = 1'b0;
    chk("mtlo lo", lo, 32'h0F0F0F0F);
    chk("mtlo hi", hi, 32'hAAAA5555);
    chk("mtlo busy", {31'b0, busy}, 0);
    chk("mtlo done", {31'b0, done}, 0);

    // Undefined op code is ignored.
    sh = hi; sl = lo;
    start = 1'b1; op = 3'd6; dataA = 32'h11111111; dataB = 32'h2;
    tick;
    start = 1'b0;
    chk("undef busy", {31'b0, busy}, 0);
    chk("undef hi", hi, sh);
    chk("undef lo", lo, sl);

    // MULT issued mid-run (count 10) must be ignored.
    do_op("ignored_mult", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 11);

    // Reset at RUN count 20 aborts and clears HI/LO.
    op = OP_MULTU; dataA = 32'd5; dataB = 32'd9; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (20) tick;
    chk("midrun busy", {31'b0, busy}, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort busy", {31'b0, busy}, 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    chk("abort done", {31'b0, done}, 0);
    do_op("post_reset", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, 0);

    // Random operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      model(o, a, b, eh, el, edz);
      do_op($sformatf("rand%0d", k), o, a, b, eh, el, edz, 1'b1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
